// File: rtl/npc_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, datapath width, reset PC.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package npc_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, reads imem one word at a time, presents {pc, inst} to the core.
// Latency: request, at least one wait cycle, then present; best case one instruction per 3 cycles.
// Backpressure: out_valid holds pc/inst until out_ready; no new imem request is made while presenting.
module ifu_fetch #(
    parameter int                XLEN     = npc_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC = npc_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst,

    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    import npc_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst_q;
    // Set when a redirect lands while a request is in flight; its response is discarded.
    logic            kill;
    logic            req_vld_q;
    logic            out_vld_q;

    // Redirect targets are forced to word alignment.
    logic [XLEN-1:0] redirect_pc_aligned;
    assign redirect_pc_aligned = redirect_pc & ~(XLEN'(3));

    // Both the request address and the presented PC come straight from the PC register.
    assign imem_req_valid = req_vld_q;
    assign imem_req_addr  = pc;
    assign out_valid      = out_vld_q;
    assign out_pc         = pc;
    assign out_inst       = inst_q;

    // Fetch FSM: redirect outranks every other event; valid outputs are registered with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_REQ;
            pc        <= RESET_PC;
            inst_q    <= '0;
            kill      <= 1'b0;
            req_vld_q <= 1'b1;
            out_vld_q <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_pc_aligned;
            case (state)
                S_REQ: begin
                    // An accepted request is already in flight; mark it for discard.
                    if (imem_req_ready) begin
                        state     <= S_WAIT;
                        kill      <= 1'b1;
                        req_vld_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        state     <= S_REQ;
                        kill      <= 1'b0;
                        req_vld_q <= 1'b1;
                    end else begin
                        kill      <= 1'b1;
                    end
                end
                S_OUT: begin
                    // Presented instruction is dropped even if out_ready is high.
                    state     <= S_REQ;
                    req_vld_q <= 1'b1;
                    out_vld_q <= 1'b0;
                end
                default: begin
                    state     <= S_REQ;
                    kill      <= 1'b0;
                    req_vld_q <= 1'b1;
                    out_vld_q <= 1'b0;
                end
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_ready) begin
                        state     <= S_WAIT;
                        req_vld_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        if (kill) begin
                            state     <= S_REQ;
                            kill      <= 1'b0;
                            req_vld_q <= 1'b1;
                        end else begin
                            state     <= S_OUT;
                            inst_q    <= imem_resp_data;
                            out_vld_q <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state     <= S_REQ;
                        pc        <= pc + XLEN'(4);
                        req_vld_q <= 1'b1;
                        out_vld_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_REQ;
                    kill      <= 1'b0;
                    req_vld_q <= 1'b1;
                    out_vld_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
